// File: rtl/snoopy_lock_manager.sv
// snoopy_lock_manager
//   Shared lock manager for NUM_PROCS processors. Each processor owns a small
//   table of held keys. One lock request is serviced at a time through a
//   three-state FSM (IDLE -> CHECK -> RESP). In CHECK the winner's key is
//   compared against every processor's table. A hit in another table blocks
//   the request. A hit in the winner's own table grants it again without using
//   a new entry. A miss allocates the lowest free entry, or blocks when the
//   winner's table is full. Releases are handled in every state, for every
//   processor, in parallel.
//
// Handshake: proc_obtain_key[p] is a level request. The requester holds it
//   until it sees a one-cycle proc_key_grant[p] or proc_key_blocked[p] pulse,
//   then drops it. A request sampled in IDLE in cycle n is answered in cycle
//   n+2. proc_key_release[p] is a one-cycle strobe. It is answered by a
//   one-cycle proc_key_release_ack[p] in the next cycle.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   proc_obtain_key[P]     lock request level per processor
//   proc_key[P*K]          requested key, slice p*KEY_WIDTH +: KEY_WIDTH
//   proc_key_release[P]    release strobe per processor
//   proc_release_key[P*K]  key to release, same slicing
//   proc_key_grant[P]      grant pulse (RESP cycle)
//   proc_key_blocked[P]    blocked pulse (RESP cycle)
//   proc_key_release_ack[P] release acknowledge pulse
//   locks_available[P]     processor p has at least one free entry
//   busy                   FSM not in IDLE (debug/visibility of FSM state)
//   fsm_state              raw FSM state for checkers
module snoopy_lock_manager #(
    parameter int NUM_PROCS     = 4,
    parameter int KEY_WIDTH     = 32,
    parameter int MAX_LOCK_KEYS = 4,
    parameter int ARB_MODE      = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PROCS-1:0]           proc_obtain_key,
    input  logic [NUM_PROCS*KEY_WIDTH-1:0] proc_key,
    input  logic [NUM_PROCS-1:0]           proc_key_release,
    input  logic [NUM_PROCS*KEY_WIDTH-1:0] proc_release_key,
    output logic [NUM_PROCS-1:0]           proc_key_grant,
    output logic [NUM_PROCS-1:0]           proc_key_blocked,
    output logic [NUM_PROCS-1:0]           proc_key_release_ack,
    output logic [NUM_PROCS-1:0]           locks_available,
    output logic                           busy,
    output logic [1:0]                     fsm_state
);

    localparam int IDX_W = (NUM_PROCS > 1) ? $clog2(NUM_PROCS) : 1;
    localparam int ENT_W = (MAX_LOCK_KEYS > 1) ? $clog2(MAX_LOCK_KEYS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]                                state;
    logic [NUM_PROCS-1:0][MAX_LOCK_KEYS-1:0]   valid_q;
    logic [KEY_WIDTH-1:0]                      key_q [NUM_PROCS][MAX_LOCK_KEYS];
    logic [IDX_W-1:0]                          last_winner;
    logic [IDX_W-1:0]                          win_idx_q;
    logic [KEY_WIDTH-1:0]                      win_key_q;
    logic                                      result_grant_q;

    // Arbiter outputs
    logic                 req_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [KEY_WIDTH-1:0] sel_key;
    int                   cand;

    // CHECK-stage lookup results
    logic                 conflict;
    logic                 own_hit;
    logic                 has_free;
    logic [ENT_W-1:0]     free_idx;
    logic                 check_grant;
    logic                 check_alloc;

    // Fixed priority scans from 0; round robin scans from last_winner+1.
    always_comb begin
        req_found = 1'b0;
        sel_idx   = '0;
        sel_key   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_PROCS; i++) begin
            if (ARB_MODE == 1)
                cand = (int'(last_winner) + 1 + i) % NUM_PROCS;
            else
                cand = i;
            if (!req_found && proc_obtain_key[cand]) begin
                req_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
                sel_key   = proc_key[cand*KEY_WIDTH +: KEY_WIDTH];
            end
        end
    end

    // Lookup uses the registered table only, so a release landing in the
    // same cycle as CHECK cannot change its outcome.
    always_comb begin
        conflict = 1'b0;
        own_hit  = 1'b0;
        has_free = 1'b0;
        free_idx = '0;
        for (int p = 0; p < NUM_PROCS; p++) begin
            for (int e = 0; e < MAX_LOCK_KEYS; e++) begin
                if (valid_q[p][e] && key_q[p][e] == win_key_q) begin
                    if (p == int'(win_idx_q))
                        own_hit = 1'b1;
                    else
                        conflict = 1'b1;
                end
            end
        end
        // Descending scan so the lowest free entry is the one kept.
        for (int e = MAX_LOCK_KEYS - 1; e >= 0; e--) begin
            if (!valid_q[win_idx_q][e]) begin
                has_free = 1'b1;
                free_idx = e[ENT_W-1:0];
            end
        end
        check_grant = !conflict && (own_hit || has_free);
        check_alloc = !conflict && !own_hit && has_free;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= ST_IDLE;
            valid_q              <= '0;
            last_winner          <= IDX_W'(NUM_PROCS - 1);
            win_idx_q            <= '0;
            win_key_q            <= '0;
            result_grant_q       <= 1'b0;
            proc_key_release_ack <= '0;
        end else begin
            proc_key_release_ack <= proc_key_release;
            for (int p = 0; p < NUM_PROCS; p++) begin
                for (int e = 0; e < MAX_LOCK_KEYS; e++) begin
                    if (proc_key_release[p] && valid_q[p][e] &&
                        key_q[p][e] == proc_release_key[p*KEY_WIDTH +: KEY_WIDTH])
                        valid_q[p][e] <= 1'b0;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (req_found) begin
                        win_idx_q   <= sel_idx;
                        win_key_q   <= sel_key;
                        last_winner <= sel_idx;
                        state       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    result_grant_q <= check_grant;
                    // Placed after the release loop so allocation wins a
                    // same-entry collision.
                    if (check_alloc) begin
                        valid_q[win_idx_q][free_idx] <= 1'b1;
                        key_q[win_idx_q][free_idx]   <= win_key_q;
                    end
                    state <= ST_RESP;
                end
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        proc_key_grant   = '0;
        proc_key_blocked = '0;
        if (state == ST_RESP) begin
            if (result_grant_q)
                proc_key_grant[win_idx_q] = 1'b1;
            else
                proc_key_blocked[win_idx_q] = 1'b1;
        end
        for (int p = 0; p < NUM_PROCS; p++)
            locks_available[p] = ~&valid_q[p];
    end

    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_snoopy_lock_manager.sv
// Directed bench for snoopy_lock_manager. dut_a uses the defaults (fixed
// priority, 4 entries per processor). dut_b uses round robin with 2 entries.
// Inputs change 1 ns after a rising edge, and outputs are sampled at the same
// point.
module tb_snoopy_lock_manager;

    localparam int NP = 4;
    localparam int KW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]    a_obtain = '0, a_rel = '0;
    logic [NP*KW-1:0] a_key = '0, a_relkey = '0;
    logic [NP-1:0]    a_grant, a_blocked, a_ack, a_avail;
    logic             a_busy;
    logic [1:0]       a_state;

    logic [NP-1:0]    b_obtain = '0, b_rel = '0;
    logic [NP*KW-1:0] b_key = '0, b_relkey = '0;
    logic [NP-1:0]    b_grant, b_blocked, b_ack, b_avail;
    logic             b_busy;
    logic [1:0]       b_state;

    int n_checks = 0;
    int n_errors = 0;

    snoopy_lock_manager #(.NUM_PROCS(NP), .KEY_WIDTH(KW), .MAX_LOCK_KEYS(4), .ARB_MODE(0)) dut_a (
        .clk(clk), .reset(reset),
        .proc_obtain_key(a_obtain), .proc_key(a_key),
        .proc_key_release(a_rel), .proc_release_key(a_relkey),
        .proc_key_grant(a_grant), .proc_key_blocked(a_blocked),
        .proc_key_release_ack(a_ack), .locks_available(a_avail),
        .busy(a_busy), .fsm_state(a_state)
    );

    snoopy_lock_manager #(.NUM_PROCS(NP), .KEY_WIDTH(KW), .MAX_LOCK_KEYS(2), .ARB_MODE(1)) dut_b (
        .clk(clk), .reset(reset),
        .proc_obtain_key(b_obtain), .proc_key(b_key),
        .proc_key_release(b_rel), .proc_release_key(b_relkey),
        .proc_key_grant(b_grant), .proc_key_blocked(b_blocked),
        .proc_key_release_ack(b_ack), .locks_available(b_avail),
        .busy(b_busy), .fsm_state(b_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full request on dut_a: CHECK, RESP, then back to IDLE.
    task automatic a_txn(input string tag, input int p, input logic [31:0] key, input bit exp_grant);
        logic [NP-1:0] oh;
        oh = NP'(1) << p;
        a_obtain[p] = 1'b1;
        a_key[p*KW +: KW] = key;
        tick();
        chk({tag, "_check_busy"}, 32'(a_busy), 32'd1);
        chk({tag, "_check_quiet"}, 32'({a_grant, a_blocked}), 32'd0);
        tick();
        chk({tag, "_grant"}, 32'(a_grant), exp_grant ? 32'(oh) : 32'd0);
        chk({tag, "_blocked"}, 32'(a_blocked), exp_grant ? 32'd0 : 32'(oh));
        a_obtain[p] = 1'b0;
        tick();
        chk({tag, "_idle"}, 32'({a_busy, a_grant, a_blocked}), 32'd0);
    endtask

    task automatic b_txn(input string tag, input int p, input logic [31:0] key, input bit exp_grant);
        logic [NP-1:0] oh;
        oh = NP'(1) << p;
        b_obtain[p] = 1'b1;
        b_key[p*KW +: KW] = key;
        tick();
        tick();
        chk({tag, "_grant"}, 32'(b_grant), exp_grant ? 32'(oh) : 32'd0);
        chk({tag, "_blocked"}, 32'(b_blocked), exp_grant ? 32'd0 : 32'(oh));
        b_obtain[p] = 1'b0;
        tick();
        chk({tag, "_idle"}, 32'({b_busy, b_grant, b_blocked}), 32'd0);
    endtask

    task automatic a_release(input string tag, input int p, input logic [31:0] key);
        a_rel[p] = 1'b1;
        a_relkey[p*KW +: KW] = key;
        tick();
        a_rel = '0;
        chk({tag, "_ack"}, 32'(a_ack), 32'(NP'(1) << p));
        tick();
        chk({tag, "_ack_off"}, 32'(a_ack), 32'd0);
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_grant", 32'(a_grant), 32'd0);
        chk("rst_blocked", 32'(a_blocked), 32'd0);
        chk("rst_ack", 32'(a_ack), 32'd0);
        chk("rst_avail", 32'(a_avail), 32'hF);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_b_avail", 32'(b_avail), 32'hF);

        // Basic grant, then conflict, release and retry
        a_txn("basic", 0, 32'h10, 1'b1);
        chk("basic_avail", 32'(a_avail), 32'hF);
        a_txn("conflict", 1, 32'h10, 1'b0);
        a_release("rel0", 0, 32'h10);
        a_txn("regrant", 1, 32'h10, 1'b1);

        // Fixed priority: four simultaneous requests are served 0,1,2,3
        a_obtain = 4'hF;
        for (int k = 0; k < NP; k++) a_key[k*KW +: KW] = 32'h100 + k;
        for (int k = 0; k < NP; k++) begin
            tick();
            tick();
            chk("fixed_order", 32'(a_grant), 32'(NP'(1) << k));
            a_obtain[k] = 1'b0;
            tick();
        end

        // Same-cycle release: proc1 CHECK sees proc0 still holding 0x10
        a_release("rel1", 1, 32'h10);
        a_txn("p0_take", 0, 32'h10, 1'b1);
        a_obtain[1] = 1'b1;
        a_key[1*KW +: KW] = 32'h10;
        tick();
        a_rel[0] = 1'b1;
        a_relkey[0 +: KW] = 32'h10;
        tick();
        chk("same_cyc_blocked", 32'(a_blocked), 32'h2);
        chk("same_cyc_ack", 32'(a_ack), 32'h1);
        a_rel = '0;
        a_obtain = '0;
        tick();
        a_txn("after_rel", 1, 32'h10, 1'b1);

        // Releasing a key that is not held is acknowledged and changes nothing
        a_release("rel_miss", 2, 32'h999);
        a_txn("p2_still", 3, 32'h102, 1'b0);

        // Reset in CHECK aborts the transaction and empties the tables
        a_obtain[2] = 1'b1;
        a_key[2*KW +: KW] = 32'h55;
        tick();
        chk("mid_in_check", 32'(a_state), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_pulses", 32'({a_grant, a_blocked}), 32'd0);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_avail", 32'(a_avail), 32'hF);
        reset = 1'b0;
        a_obtain = '0;
        tick();
        chk("mid_rst_no_resp", 32'({a_grant, a_blocked}), 32'd0);
        a_txn("post_rst_102", 3, 32'h102, 1'b1);
        a_txn("post_rst_55", 0, 32'h55, 1'b1);

        // Two processors release in the same cycle
        a_rel = 4'b1001;
        a_relkey[0 +: KW] = 32'h55;
        a_relkey[3*KW +: KW] = 32'h102;
        tick();
        a_rel = '0;
        chk("multi_rel_ack", 32'(a_ack), 32'h9);
        a_txn("multi_55", 1, 32'h55, 1'b1);
        a_txn("multi_102", 1, 32'h102, 1'b1);

        // Table full with two entries, then the re-entrant grant
        b_txn("full_a", 2, 32'hA, 1'b1);
        chk("full_avail1", 32'(b_avail), 32'hF);
        b_txn("full_b", 2, 32'hB, 1'b1);
        chk("full_avail2", 32'(b_avail), 32'hB);
        b_txn("full_c", 2, 32'hC, 1'b0);
        b_txn("reentrant", 2, 32'hA, 1'b1);
        chk("reent_avail", 32'(b_avail), 32'hB);

        // Round robin: with last_winner at 1 the order is 2,3,0,1
        b_rel[2] = 1'b1;
        b_relkey[2*KW +: KW] = 32'hB;
        tick();
        b_rel = '0;
        chk("b_rel_ack", 32'(b_ack), 32'h4);
        b_txn("rr_prime", 1, 32'h200, 1'b1);
        b_obtain = 4'hF;
        for (int k = 0; k < NP; k++) b_key[k*KW +: KW] = 32'h300 + k;
        for (int k = 0; k < NP; k++) begin
            int w;
            w = (2 + k) % NP;
            tick();
            tick();
            chk("rr_order", 32'(b_grant), 32'(NP'(1) << w));
            b_obtain[w] = 1'b0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/snoopy_lock_manager.md
SNOOPY_LOCK_MANAGER -- requirements
Module: snoopy_lock_manager

Interface
REQ-001 Parameter NUM_PROCS, default 4: number of processor ports, at least 2.
REQ-002 Parameter KEY_WIDTH, default 32: width of each key.
REQ-003 Parameter MAX_LOCK_KEYS, default 4: lock-table entries per processor, at least 1.
REQ-004 Parameter ARB_MODE, default 0: 0 selects fixed priority (lowest index wins); 1 selects round robin.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port proc_obtain_key, input, NUM_PROCS bits: per-processor lock request (level).
REQ-008 Port proc_key, input, NUM_PROCS*KEY_WIDTH bits: requested key; processor p occupies slice [p*KEY_WIDTH +: KEY_WIDTH].
REQ-009 Port proc_key_release, input, NUM_PROCS bits: per-processor release strobe (one cycle).
REQ-010 Port proc_release_key, input, NUM_PROCS*KEY_WIDTH bits: key to release, same slicing as proc_key.
REQ-011 Port proc_key_grant, output, NUM_PROCS bits: one-cycle pulse when a lock is granted.
REQ-012 Port proc_key_blocked, output, NUM_PROCS bits: one-cycle pulse when a lock is refused.
REQ-013 Port proc_key_release_ack, output, NUM_PROCS bits: one-cycle pulse acknowledging a release.
REQ-014 Port locks_available, output, NUM_PROCS bits: high while processor p has at least one free table entry.
REQ-015 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-016 Each processor SHALL own a table of MAX_LOCK_KEYS entries, each holding a valid bit and a key.
REQ-017 The FSM SHALL have states IDLE, CHECK and RESP, moving IDLE->CHECK->RESP->IDLE.
REQ-018 In IDLE with any proc_obtain_key bit high, the block SHALL select a winner, latch its index and key, and enter CHECK; with no request it SHALL stay in IDLE.
REQ-019 With ARB_MODE=0 the winner SHALL be the lowest-index requester.
REQ-020 With ARB_MODE=1 the search SHALL start at (last_winner+1) mod NUM_PROCS; last_winner resets to NUM_PROCS-1, so proc 0 has first priority.
REQ-021 In CHECK, a latched key matching a valid entry of any other processor's table SHALL produce a conflict result (blocked).
REQ-022 In CHECK, a latched key already valid in the winner's own table SHALL produce a grant without allocating a new entry (re-entrant lock).
REQ-023 In CHECK, with no match and no free entry in the winner's table, the result SHALL be blocked.
REQ-024 In CHECK, with no match and a free entry, the block SHALL write the key into the lowest-index free entry and the result SHALL be grant.
REQ-025 In RESP, exactly one of proc_key_grant[w] or proc_key_blocked[w] SHALL be high for that one cycle only, then the FSM returns to IDLE.
REQ-026 Latency: a request sampled in IDLE in cycle n SHALL receive its response in cycle n+2; throughput is one transaction per 3 cycles.
REQ-027 A requester SHALL drop proc_obtain_key in the cycle after its grant/blocked pulse; a request dropped during CHECK/RESP SHALL still be completed.
REQ-028 A release of processor p SHALL be processed in any FSM state: it clears every valid entry of p equal to proc_release_key[p], and proc_key_release_ack[p] pulses the next cycle.
REQ-029 A release of a key not held SHALL still be acknowledged and SHALL leave the table unchanged.
REQ-030 Several processors releasing in the same cycle SHALL all be processed in that cycle.
REQ-031 CHECK SHALL use table contents registered at the start of the cycle; a release in the same cycle does not change that CHECK result.
REQ-032 If allocation and release target the same entry in the same cycle, the allocation write SHALL win.
REQ-033 locks_available[p] SHALL be combinational from p's valid bits.
REQ-034 busy SHALL be combinational from the FSM state.

Reset
REQ-035 Reset SHALL force IDLE, clear all valid bits, and set last_winner to NUM_PROCS-1.
REQ-036 Reset SHALL drive grant, blocked and release_ack to 0, locks_available to all ones, and busy to 0.
REQ-037 Reset asserted mid-transaction SHALL abort it with no response pulse and no allocation.

Verification
REQ-038 Basic grant: proc0 requests key 0x10 -> proc_key_grant[0] pulses 2 cycles later; locks_available[0] stays 1 when MAX_LOCK_KEYS=4.
REQ-039 Conflict and release: proc0 holds 0x10; proc1 requests 0x10 -> blocked[1]; proc0 releases 0x10 -> ack[0] next cycle; proc1 re-requests -> grant[1].
REQ-040 Table full: MAX_LOCK_KEYS=2; proc2 locks 0xA then 0xB -> locks_available[2]=0; request 0xC -> blocked; re-request 0xA -> grant (re-entrant).
REQ-041 Arbitration: procs 0..3 request distinct keys simultaneously; ARB_MODE=0 grants in order 0,1,2,3; ARB_MODE=1 with last_winner=1 grants in order 2,3,0,1; grants are 3 cycles apart.
REQ-042 Same-cycle release: release of 0x10 by proc0 in the CHECK cycle of proc1's request for 0x10 -> blocked[1] and ack[0].
REQ-043 Reset mid-operation: reset asserted in CHECK -> no grant pulse, all tables empty, busy=0 in the following cycle.
